// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types, widths and helpers for the MLP dot-product sequencer
package mlp_pkg;

    localparam int DATA_W  = 18;
    localparam int PROD_W  = 31;
    localparam int ACC_W   = 42;
    localparam int MUL_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } dot_state_t;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v,
                                                    input logic en);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

endpackage

// File: rtl/mlp_dot_vpipe.sv
// rtl/mlp_dot_vpipe.sv - ce-gated valid shift register tracking products in flight
module mlp_dot_vpipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic din,
    output logic last,
    output logic empty
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else if (ce) begin
            pipe <= {pipe[DEPTH-2:0], din};
        end
    end

    assign last  = pipe[DEPTH-1];
    // The retiring stage is excluded: its product lands this cycle, so nothing is left afterwards.
    assign empty = ~|pipe[DEPTH-2:0];

endmodule

// File: rtl/mlp_dot_seq.sv
// rtl/mlp_dot_seq.sv - sequences one neuron dot product through the shared pipelined multiplier
module mlp_dot_seq
    import mlp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [PROD_W-1:0] bias,
    input  logic              relu_en,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] w_data,
    output logic              mul_ce,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    dot_state_t              state, state_next;
    logic [ADDR_W:0]         len_q;
    logic [ADDR_W:0]         cnt;
    logic                    relu_q;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic                    vp_last, vp_empty;

    assign busy      = (state != IDLE);
    assign rd_en     = (state == RUN);
    assign mul_ce    = (state == RUN) || (state == DRAIN);
    assign out_valid = (state == OUT);
    assign rd_addr   = cnt[ADDR_W-1:0];
    assign mul_a     = x_data;
    assign mul_b     = w_data;

    mlp_dot_vpipe #(
        .DEPTH(1 + MUL_LAT)
    ) u_vpipe (
        .clk  (clk),
        .reset(reset),
        .ce   (mul_ce),
        .din  (rd_en),
        .last (vp_last),
        .empty(vp_empty)
    );

    always_comb begin
        acc_next = acc;
        if (mul_ce && vp_last) begin
            acc_next = acc + sext_prod(mul_p);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (len == '0) ? OUT : RUN;
            // Counter is one bit wider than the address so len = 2^ADDR_W terminates correctly.
            RUN:   if (cnt + 1'b1 == len_q) state_next = DRAIN;
            DRAIN: if (vp_empty) state_next = OUT;
            OUT:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt      <= '0;
            relu_q   <= 1'b0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        relu_q <= relu_en;
                        acc    <= sext_prod(bias);
                        cnt    <= '0;
                        if (len == '0) begin
                            out_data <= relu_clamp(sext_prod(bias), relu_en);
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_next;
                end
                DRAIN: begin
                    acc <= acc_next;
                    if (vp_empty) begin
                        out_data <= relu_clamp(acc_next, relu_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_dot_seq.sv
// tb/tb_mlp_dot_seq.sv - randomized self-checking bench for mlp_dot_seq with memory and multiplier models
module tb_mlp_dot_seq;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 18;
    localparam int PROD_W = 31;
    localparam int ACC_W  = 42;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [PROD_W-1:0] bias;
    logic              relu_en;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] x_data = '0;
    logic [DATA_W-1:0] w_data = '0;
    logic              mul_ce;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    int vectors = 0;
    int miscompares = 0;

    logic signed [DATA_W-1:0] x_mem [DEPTH];
    logic signed [DATA_W-1:0] w_mem [DEPTH];

    logic signed [DATA_W-1:0]   a_r = '0;
    logic signed [DATA_W-1:0]   b_r = '0;
    logic signed [2*DATA_W-1:0] prod_full;
    logic [PROD_W-1:0]          p_r = '0;

    always #5 clk = ~clk;

    mlp_dot_seq #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bias     (bias),
        .relu_en  (relu_en),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .x_data   (x_data),
        .w_data   (w_data),
        .mul_ce   (mul_ce),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // Synchronous-read activation/weight memories.
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= x_mem[rd_addr];
            w_data <= w_mem[rd_addr];
        end
    end

    // Two-stage multiplier; the product port carries PROD_W bits.
    assign prod_full = a_r * b_r;
    always @(posedge clk) begin
        if (mul_ce) begin
            a_r <= mul_a;
            b_r <= mul_b;
            p_r <= prod_full[PROD_W-1:0];
        end
    end
    assign mul_p = p_r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] ref_dot(input int n, input logic signed [PROD_W-1:0] b,
                                                 input bit relu);
        longint                   s;
        longint                   p;
        logic signed [PROD_W-1:0] pt;
        logic signed [ACC_W-1:0]  r;
        s = b;
        for (int i = 0; i < n; i++) begin
            p  = longint'(x_mem[i]) * longint'(w_mem[i]);
            pt = p[PROD_W-1:0];
            s  = s + pt;
        end
        r = s[ACC_W-1:0];
        if (relu && r < 0) r = '0;
        return r;
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            x_mem[i] = DATA_W'($urandom);
            w_mem[i] = DATA_W'($urandom);
        end
    endtask

    task automatic run_job(input int n, input logic [PROD_W-1:0] b, input bit relu,
                           input int hold, input bit poke);
        logic [ACC_W-1:0] expd;
        logic [ACC_W-1:0] held;
        int cyc, reads, addr_err, unstable;
        expd    = ref_dot(n, b, relu);
        start   = 1'b1;
        len     = n[ADDR_W:0];
        bias    = b;
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; reads = 0; addr_err = 0;
        while (!out_valid && cyc < n + 20) begin
            if (rd_en) begin
                if (rd_addr !== reads[ADDR_W-1:0]) addr_err++;
                reads++;
            end
            start   = poke && (cyc == 2);
            len     = start ? 11'd3 : n[ADDR_W:0];
            relu_en = start ? ~relu : relu;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        len   = n[ADDR_W:0];
        relu_en = relu;
        chk("latency", 64'(cyc), 64'((n == 0) ? 1 : n + 4));
        chk("result", 64'(out_data), 64'(expd));
        chk("reads", 64'(reads), 64'(n));
        chk("rd_addr_seq", 64'(addr_err), 64'd0);
        held = out_data;
        unstable = 0;
        for (int k = 0; k < hold; k++) begin
            start = poke && (k == 3);
            @(negedge clk);
            if (!out_valid || out_data !== held) unstable++;
        end
        start = 1'b0;
        if (hold > 0) chk("hold_stable", 64'(unstable), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("accept", 64'({out_valid, busy}), 64'd0);
    endtask

    initial begin
        logic signed [PROD_W-1:0] bm7;
        int seen, guard;
        bm7 = -7;
        reset = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_mul_ce", 64'(mul_ce), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed small job, held output with start pokes, then back-to-back jobs.
        for (int i = 0; i < 4; i++) begin
            x_mem[i] = DATA_W'(i + 1);
            w_mem[i] = DATA_W'(i + 5);
        end
        chk("ref_small", 64'(ref_dot(4, 31'd10, 1'b0)), 64'd80);
        run_job(4, 31'd10, 1'b0, 20, 1'b1);
        run_job(0, bm7, 1'b0, 0, 1'b0);
        run_job(0, bm7, 1'b1, 2, 1'b0);

        // Full-length jobs at full-scale operands.
        for (int i = 0; i < DEPTH; i++) begin
            x_mem[i] = -18'sd131072;
            w_mem[i] = -18'sd131072;
        end
        run_job(DEPTH, 31'd0, 1'b0, 1, 1'b0);
        for (int i = 0; i < DEPTH; i++) w_mem[i] = 18'sd131071;
        run_job(DEPTH, 31'd0, 1'b0, 0, 1'b1);
        fill_rand(DEPTH);
        run_job(DEPTH, PROD_W'($urandom), 1'b1, 1, 1'b0);

        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_rand(n);
            run_job(n, PROD_W'($urandom), 1'($urandom), $urandom_range(0, 6), 1'b1);
        end

        // Reset in the middle of a len=8 job.
        fill_rand(8);
        start = 1'b1; len = 11'd8; bias = PROD_W'($urandom); relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(rd_en && rd_addr == 10'd3) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_issue3", 64'(guard < 20), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rd_en", 64'(rd_en), 64'd0);
        chk("mid_mul_ce", 64'(mul_ce), 64'd0);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_out_data", 64'(out_data), 64'd0);
        chk("mid_rd_addr", 64'(rd_addr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_en || out_valid || busy) seen++;
        end
        chk("post_reset_quiet", 64'(seen), 64'd0);
        fill_rand(2);
        run_job(2, PROD_W'($urandom), 1'b0, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
